// File: rtl/steer_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | steer_arbiter: shares the steering position register between the video   |
// | tracker and the override controller; optional STEER_RATE_LIMIT_EN clamp.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module steer_arbiter #(
  parameter logic [7:0]  POS_MIN  = 8'd0,
  parameter logic [7:0]  POS_MAX  = 8'd255,
  parameter logic [7:0]  POS_INIT = 8'd128,
  parameter logic [15:0] HOLDOFF  = 16'd1000,
  parameter logic [7:0]  MAX_STEP = 8'd8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trk_valid,
  input  logic       trk_dir,
  input  logic [7:0] trk_val,
  output logic       trk_grant,
  input  logic       ovr_valid,
  input  logic       ovr_dir,
  input  logic [7:0] ovr_val,
  output logic       ovr_grant,
  output logic [7:0] pos,
  output logic       pos_valid,
  input  logic       drv_ready,
  output logic       owner,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_slot_full;
  logic        r_slot_dir;
  logic [7:0]  r_slot_val;
  logic        r_dir;
  logic [7:0]  r_val;
  logic [15:0] r_holdoff;
  logic        r_trk_grant;
  logic        r_ovr_grant;
  logic [7:0]  r_pos;
  logic        r_pos_valid;

  logic        w_ovr_pend;
  logic        w_ovr_dir;
  logic [7:0]  w_ovr_val;
  logic        w_ovr_take;
  logic        w_trk_take;
  logic        w_pos_load;
  logic [7:0]  w_step;
  logic [8:0]  w_sum;
  logic [7:0]  w_next_pos;

  // A strobe arriving this very cycle is visible before it lands in the slot.
  assign w_ovr_pend = r_slot_full | ovr_valid;
  assign w_ovr_dir  = ovr_valid ? ovr_dir : r_slot_dir;
  assign w_ovr_val  = ovr_valid ? ovr_val : r_slot_val;

`ifdef STEER_RATE_LIMIT_EN
  assign w_step = (r_val > MAX_STEP) ? MAX_STEP : r_val;
`else
  logic w_unused_max_step;
  assign w_step            = r_val;
  assign w_unused_max_step = ^MAX_STEP;
`endif

  assign w_sum = {1'b0, r_pos} + {1'b0, w_step};

  always_comb begin
    w_next_pos = r_pos;
    if (r_dir) begin
      if ({1'b0, r_pos} < ({1'b0, w_step} + {1'b0, POS_MIN}))
        w_next_pos = POS_MIN;
      else
        w_next_pos = r_pos - w_step;
    end else begin
      if (w_sum > {1'b0, POS_MAX})
        w_next_pos = POS_MAX;
      else
        w_next_pos = w_sum[7:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ovr_take   = 1'b0;
    w_trk_take   = 1'b0;
    w_pos_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ovr_pend) begin
          w_ovr_take   = 1'b1;
          w_state_next = S_APPLY;
        end else if (trk_valid && (r_holdoff == 16'd0)) begin
          w_trk_take   = 1'b1;
          w_state_next = S_APPLY;
        end
      end
      S_APPLY: begin
        if (w_next_pos != r_pos) begin
          w_pos_load   = 1'b1;
          w_state_next = S_ISSUE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (drv_ready)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_slot_full <= 1'b0;
      r_slot_dir  <= 1'b0;
      r_slot_val  <= 8'd0;
      r_dir       <= 1'b0;
      r_val       <= 8'd0;
      r_holdoff   <= 16'd0;
      r_trk_grant <= 1'b0;
      r_ovr_grant <= 1'b0;
      r_pos       <= POS_INIT;
      r_pos_valid <= 1'b0;
    end else begin
      r_trk_grant <= w_trk_take;
      r_ovr_grant <= w_ovr_take;

      // The slot empties once its grant is out, unless a newer strobe lands.
      if (ovr_valid) begin
        r_slot_full <= 1'b1;
        r_slot_dir  <= ovr_dir;
        r_slot_val  <= ovr_val;
      end else if (r_ovr_grant) begin
        r_slot_full <= 1'b0;
      end

      if (w_ovr_take) begin
        r_dir     <= w_ovr_dir;
        r_val     <= w_ovr_val;
        r_holdoff <= HOLDOFF;
      end else begin
        if (w_trk_take) begin
          r_dir <= trk_dir;
          r_val <= trk_val;
        end
        if (r_holdoff != 16'd0)
          r_holdoff <= r_holdoff - 16'd1;
      end

      if (w_pos_load) begin
        r_pos       <= w_next_pos;
        r_pos_valid <= 1'b1;
      end else if ((r_state == S_ISSUE) && drv_ready) begin
        r_pos_valid <= 1'b0;
      end
    end
  end

  assign trk_grant = r_trk_grant;
  assign ovr_grant = r_ovr_grant;
  assign pos       = r_pos;
  assign pos_valid = r_pos_valid;
  assign owner     = (r_holdoff != 16'd0);
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/steer_arbiter.md
Name: steer_arbiter

Overview:
- Owns the steering actuator position register and shares it between two requesters.
- Requester 1 is the video tracker (relative step requests).
- Requester 2 is the voice/switch override controller (dir/val/done pulses).
- Override has priority; a hold-off window after each override locks out the tracker.
- Each accepted step updates a saturated absolute position, which is presented to the motor/servo driver with a valid/ready handshake.

Parameters:
- POS_MIN, 8'd0: lower saturation limit of pos.
- POS_MAX, 8'd255: upper saturation limit of pos.
- POS_INIT, 8'd128: reset value of pos.
- HOLDOFF, 16'd1000: cycles after an override grant during which tracker requests are not granted.
- MAX_STEP, 8'd8: per-command step clamp; used only when STEER_RATE_LIMIT_EN is defined.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- trk_valid  input  1  tracker request; held by the tracker until trk_grant.
- trk_dir  input  1  tracker direction: 0 = right (increment), 1 = left (decrement).
- trk_val  input  8  tracker step magnitude.
- trk_grant  output  1  one-cycle pulse: tracker request consumed.
- ovr_valid  input  1  override done strobe; may be a single-cycle pulse or held (GO mode).
- ovr_dir  input  1  override direction, same encoding as trk_dir.
- ovr_val  input  8  override step magnitude.
- ovr_grant  output  1  one-cycle pulse: override request consumed.
- pos  output  8  current absolute actuator position.
- pos_valid  output  1  new position offered to the driver.
- drv_ready  input  1  driver accepts pos when pos_valid && drv_ready.
- owner  output  1  1 while hold-off counter is nonzero (override owns the actuator), else 0.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset values: pos = POS_INIT, pos_valid = 0, trk_grant = 0, ovr_grant = 0, owner = 0, busy = 0.
- Reset also clears: state = IDLE, hold-off counter = 0, override pending slot empty.
- Reset mid-operation aborts any handshake immediately. No position is issued after reset until the first granted request.
- Override pending slot (1 deep):
  - Set on any cycle with ovr_valid = 1; captures ovr_dir/ovr_val, and a newer strobe overwrites older contents.
  - Cleared on ovr_grant, except when ovr_valid is also high that cycle: the new strobe wins and the slot stays full.
- States:
  - IDLE:
    - At an edge where the slot is full → ovr_grant = 1 next cycle; latch slot dir/val; load hold-off counter with HOLDOFF; → APPLY.
    - Else, at an edge where trk_valid = 1 and hold-off counter = 0 → trk_grant = 1 next cycle; latch trk_dir/trk_val; → APPLY.
    - Simultaneous override and tracker: override wins; the tracker remains pending (no grant).
  - APPLY (1 cycle):
    - Compute next = pos ± val in 9-bit arithmetic, saturated to [POS_MIN, POS_MAX].
    - If next != pos: pos <= next, pos_valid <= 1, → ISSUE.
    - Else (val = 0, or already at the limit): no issue, → IDLE.
  - ISSUE: hold pos and pos_valid stable until an edge with drv_ready = 1, then pos_valid <= 0, → IDLE.
- Latency: request sampled at edge E0 → grant pulse in cycle E0..E1 → pos/pos_valid updated at E1. Minimum 3 cycles per command with drv_ready tied high.
- Hold-off counter:
  - Decrements by 1 every cycle while nonzero, in any state.
  - Reloads to HOLDOFF on every ovr_grant, including while already nonzero.
  - owner = (counter != 0).
- Grants are single-cycle and never both asserted in the same cycle.
- A tracker request arriving during APPLY or ISSUE waits; it is not dropped.

Optional Feature:
- Macro: STEER_RATE_LIMIT_EN.
- Defined: the latched val is clamped to min(val, MAX_STEP) in APPLY, for both requesters.
- Not defined: val is used unmodified; MAX_STEP is unused.

Test Plan:
- Reset, then tracker request dir=0 val=5, drv_ready=1 → trk_grant pulse; pos = 133 with pos_valid for 1 cycle; owner = 0.
- Tracker and override requests in the same cycle (ovr dir=1 val=2) → ovr_grant only; pos = 126; tracker is not granted until HOLDOFF (test value 20) cycles after ovr_grant; owner = 1 throughout that window.
- pos = 250, override dir=0 val=20 → pos saturates to 255. A second identical override → no pos_valid; returns to IDLE; ovr_grant still pulses.
- drv_ready held low for 10 cycles while in ISSUE → pos and pos_valid stable all 10 cycles. An ovr_valid pulse during that window is latched and granted on the first IDLE cycle.
- Reset asserted mid-ISSUE → next cycle pos = 128, pos_valid = 0, owner = 0, busy = 0, and the pending slot is empty (no later grant occurs).
- With STEER_RATE_LIMIT_EN defined: tracker dir=1 val=30 from pos 128 → pos = 120.
